system_btn_event_ctrl: RTL

Button event controller for the push-button PIO subsystem. It synchronizes and debounces `N_BTN` raw button inputs and detects press and release edges. A round-robin arbiter serializes simultaneous edges into an event FIFO, which the CPU drains through a 4-word Avalon-MM slave. A single level interrupt asserts while events are queued.

---
 rtl/system_btn_event_ctrl.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/system_btn_event_ctrl.sv
// Button event controller: synchronizes and debounces raw buttons, turns
// accepted level changes into press/release events, serializes them with a
// round-robin arbiter into an event FIFO, and exposes everything through a
// 4-word Avalon-MM slave with a single level interrupt.
module system_btn_event_ctrl #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              read_n,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  input  logic [N_BTN-1:0]  btn_in
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int PW = (N_BTN > 1) ? $clog2(N_BTN) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = AW + 1;

  typedef enum logic [1:0] {
    REG_STATUS  = 2'd0,
    REG_EVENT   = 2'd1,
    REG_MASK    = 2'd2,
    REG_CONTROL = 2'd3
  } reg_addr_e;

  // FIFO entry: {type (1 = press), button index}
  typedef struct packed {
    logic       is_press;
    logic [3:0] idx;
  } event_t;

  // Synchronizer and debounce state
  logic [N_BTN-1:0] s1_q, s2_q;
  logic [N_BTN-1:0] stable_q, stable_d;
  logic [CW-1:0]    cnt_q [N_BTN];
  logic [CW-1:0]    cnt_d [N_BTN];
  logic [N_BTN-1:0] rise, fall;

  // Pending flags and arbiter
  logic [N_BTN-1:0] pend_q, pend_d;
  logic [N_BTN-1:0] ptype_q, ptype_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic             grant_vld;
  logic [PW-1:0]    grant_idx;
  logic             arb_en;
  logic             ovf_set;

  // FIFO
  event_t           mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]    count_q, count_d;
  logic             empty, full, push, pop, flush;
  event_t           head, push_entry;

  // Control registers and bus
  logic             ovf_q, ovf_d;
  logic             mask_q, mask_d;
  logic             rel_en_q, rel_en_d;
  logic [31:0]      readdata_q, rd_mux;
  logic             rd_strobe, mask_wr, ctrl_wr;
  logic             unused_wdata;

  assign unused_wdata = ^writedata[31:3];

  assign rd_strobe = chipselect & ~read_n;
  assign mask_wr   = chipselect & ~write_n & (address == REG_MASK);
  assign ctrl_wr   = chipselect & ~write_n & (address == REG_CONTROL);
  assign flush     = ctrl_wr & writedata[0];

  assign empty = (count_q == '0);
  assign full  = (count_q == NW'(FIFO_DEPTH));
  assign pop   = rd_strobe & (address == REG_EVENT) & ~empty;
  assign head  = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot, so a full FIFO can still accept a grant.
  assign arb_en = ~flush & (~full | pop);
  assign push   = grant_vld;

  assign push_entry.is_press = ptype_q[grant_idx];
  assign push_entry.idx      = 4'(grant_idx);

  // Debounce: count cycles of mismatch, accept the new level after DEBOUNCE_CYCLES of it
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    stable_d = stable_q;
    rise     = '0;
    fall     = '0;
    for (int i = 0; i < N_BTN; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          stable_d[i] = s2_q[i];
          rise[i]     = s2_q[i];
          fall[i]     = ~s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Round-robin search starting one past the last granted button
  always_comb begin
    logic [PW-1:0] cand;
    grant_vld = 1'b0;
    grant_idx = ptr_q;
    cand      = '0;
    for (int k = 1; k <= N_BTN; k++) begin
      cand = PW'((int'(ptr_q) + k) % N_BTN);
      if (arb_en && !grant_vld && pend_q[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Pending flags: new edges set/overwrite, a grant clears; overwriting an ungranted event is an overflow
  always_comb begin
    pend_d  = pend_q;
    ptype_d = ptype_q;
    ptr_d   = ptr_q;
    ovf_set = 1'b0;
    if (grant_vld) begin
      pend_d[grant_idx] = 1'b0;
      ptr_d             = grant_idx;
    end
    for (int i = 0; i < N_BTN; i++) begin
      if (rise[i] || (fall[i] && rel_en_q)) begin
        if (pend_q[i] && !(grant_vld && grant_idx == PW'(i))) begin
          ovf_set = 1'b1;
        end
        pend_d[i]  = 1'b1;
        ptype_d[i] = rise[i];
      end
    end
  end

  // FIFO pointers/count and control registers; flush beats a same-cycle pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    mask_d   = mask_q;
    rel_en_d = rel_en_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + NW'(1);
      else if (pop && !push) count_d = count_q - NW'(1);
    end
    if (mask_wr) mask_d = writedata[0];
    if (ctrl_wr) begin
      rel_en_d = writedata[1];
      if (writedata[2]) ovf_d = 1'b0;
    end
    if (ovf_set) ovf_d = 1'b1;
  end

  // Register read mux; EVENT returns the head entry or 0 when empty
  always_comb begin
    rd_mux = '0;
    unique case (reg_addr_e'(address))
      REG_STATUS:  rd_mux = {empty, ovf_q, 9'b0, 5'(count_q), 16'(stable_q)};
      REG_EVENT:   rd_mux = empty ? 32'h0 : {1'b1, 22'b0, head.is_press, 4'b0, head.idx};
      REG_MASK:    rd_mux = {31'b0, mask_q};
      REG_CONTROL: rd_mux = {30'b0, rel_en_q, 1'b0};
      default:     rd_mux = '0;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      s1_q       <= '0;
      s2_q       <= '0;
      stable_q   <= '0;
      for (int i = 0; i < N_BTN; i++) cnt_q[i] <= '0;
      pend_q     <= '0;
      ptype_q    <= '0;
      ptr_q      <= PW'(N_BTN - 1);
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      mask_q     <= 1'b0;
      rel_en_q   <= 1'b0;
      readdata_q <= '0;
    end else begin
      s1_q       <= btn_in;
      s2_q       <= s1_q;
      stable_q   <= stable_d;
      for (int i = 0; i < N_BTN; i++) cnt_q[i] <= cnt_d[i];
      pend_q     <= pend_d;
      ptype_q    <= ptype_d;
      ptr_q      <= ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      mask_q     <= mask_d;
      rel_en_q   <= rel_en_d;
      readdata_q <= rd_mux;
    end
  end

  // FIFO storage write port
  always_ff @(posedge clk) begin
    // NOTE: the storage array is not reset; the count and pointers alone define which entries are valid.
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign readdata = readdata_q;
  assign irq      = mask_q & ~empty;

endmodule
